stream_upsizer: RTL and testbench
=================================

STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width in bits of one input beat (>= 1).
REQ-002 SHALL have parameter RATIO, default 4, number of input beats packed per output word (>= 2).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_data_i  input  WIDTH  input beat payload.
REQ-006 SHALL have port in_valid_i  input  1  input beat valid.
REQ-007 SHALL have port in_ready_o  output  1  input beat ready.
REQ-008 SHALL have port in_last_i  input  1  final beat of a packet; payload, qualified by in_valid_i.
REQ-009 SHALL have port out_data_o  output  WIDTH*RATIO  packed output word.
REQ-010 SHALL have port out_valid_o  output  1  output word valid.
REQ-011 SHALL have port out_ready_i  input  1  output word ready.
REQ-012 SHALL have port out_keep_o  output  RATIO  per-lane valid mask of the output word.
REQ-013 SHALL have port out_last_o  output  1  output word closes a packet.

Function
REQ-014 SHALL transfer a beat when in_valid_i && in_ready_o, and a word when out_valid_o && out_ready_i (AXI-style rules).
REQ-015 SHALL hold a lane counter cnt (width $clog2(RATIO)) and an assembly buffer of RATIO-1 lanes; beat k of a word goes to lane k, lane 0 at LSBs.
REQ-016 SHALL treat an accepted beat as closing when cnt == RATIO-1, or when in_last_i is set and the macro of REQ-027 is defined.
REQ-017 SHALL drive in_ready_o = 1 for non-closing beats; for closing beats in_ready_o = !out_valid_o || out_ready_i.
REQ-018 SHALL on a non-closing accepted beat store it in lane cnt and increment cnt.
REQ-019 SHALL on a closing accepted beat load the output register from the assembly buffer plus the current beat in lane cnt, assert out_valid_o next cycle, clear cnt to 0.
REQ-020 SHALL have latency one cycle from closing-beat acceptance to out_valid_o high; no combinational in-to-out data path.
REQ-021 SHALL keep out_data_o, out_keep_o, out_last_o stable and out_valid_o high while out_valid_o && !out_ready_i.
REQ-022 SHALL clear out_valid_o after a word transfer unless a closing beat is accepted in the same cycle, in which case the new word loads with no bubble.
REQ-023 SHALL sustain one beat per cycle indefinitely when out_ready_i is held high.
REQ-024 SHALL drive zero in lanes whose out_keep_o bit is 0.

Reset
REQ-025 SHALL on rst_i set cnt = 0, out_valid_o = 0, out_data_o = 0, out_keep_o = 0, out_last_o = 0 and clear the assembly buffer.
REQ-026 SHALL discard any partially assembled word or pending output word when rst_i is asserted mid-operation; in_ready_o SHALL read 1 in the cycle after reset.

Configuration
REQ-027 SHALL with STREAM_UPSIZER_LAST_EN defined close on in_last_i: out_keep_o has lanes 0..cnt set, out_last_o = 1, higher lanes zero; full words without last have out_keep_o all ones and out_last_o = 0.
REQ-028 SHALL without STREAM_UPSIZER_LAST_EN ignore in_last_i, drive out_keep_o all ones and out_last_o = 0 for every word, and close only at cnt == RATIO-1.

Verification (WIDTH=8, RATIO=4)
REQ-029 SHALL cover: beats 0x11,0x22,0x33,0x44 back to back, out_ready_i=1 -> out_data_o=0x44332211, out_keep_o=0xF, out_valid_o high one cycle after beat 0x44.
REQ-030 SHALL cover: out_ready_i=0 with word 0x44332211 pending, send 0x55..0x88 -> 0x55,0x66,0x77 accepted, in_ready_o=0 on 0x88, out_data_o stable; out_ready_i=1 -> 0x88776655 next.
REQ-031 SHALL cover: 16 consecutive beats, out_ready_i=1 -> 4 words, in_ready_o never low, output words on consecutive 4-cycle spacing.
REQ-032 SHALL cover: 0xAA, 0xBB with in_last_i -> macro on: out_data_o=0x0000BBAA, out_keep_o=0x3, out_last_o=1; macro off: no word until two further beats.
REQ-033 SHALL cover: rst_i after beats 0x01,0x02, then 0x0A..0x0D -> out_data_o=0x0D0C0B0A, no trace of 0x01/0x02.
REQ-034 SHALL cover: out_valid_o=1, out_ready_i=1 in the cycle closing beat accepted -> next word presented the following cycle, out_valid_o never drops.

Source files
------------

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow beats into one wide word behind a registered output stage.
// Define STREAM_UPSIZER_LAST_EN to let in_last_i close a short word (partial keep mask, last flag).

module stream_upsizer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_last_i,
    output logic [WIDTH*RATIO-1:0]   out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [RATIO-1:0]         out_keep_o,
    output logic                     out_last_o
);

    localparam int CNT_W = $clog2(RATIO);
    localparam int BUF_W = (RATIO - 1) * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]       cnt_r;
    logic [BUF_W-1:0]       buf_r;
    logic [WIDTH*RATIO-1:0] out_data_r;
    logic [RATIO-1:0]       out_keep_r;
    logic                   out_last_r;
    logic                   out_valid_r;

    logic                   last_s;
    logic                   closing_s;
    logic                   in_ready_s;
    logic                   beat_acc_s;
    logic [WIDTH*RATIO-1:0] word_s;
    logic [RATIO-1:0]       keep_s;

`ifdef STREAM_UPSIZER_LAST_EN
    assign last_s = in_last_i;
`else
    logic unused_last_s;
    assign last_s        = 1'b0;
    assign unused_last_s = in_last_i;
`endif

    // Closing beats need room in the output register; all other beats are always accepted.
    always_comb begin
        closing_s = (cnt_r == CNT_MAX) || last_s;
        if (closing_s) begin
            in_ready_s = !out_valid_r || out_ready_i;
        end else begin
            in_ready_s = 1'b1;
        end
        beat_acc_s = in_valid_i && in_ready_s;
    end

    // Candidate word: buffered lanes below cnt, the live beat at cnt, zeros above.
    always_comb begin
        word_s = '0;
        keep_s = '0;
        for (int l = 0; l < RATIO - 1; l++) begin
            if (l < int'(cnt_r)) begin
                word_s[l*WIDTH +: WIDTH] = buf_r[l*WIDTH +: WIDTH];
                keep_s[l]                = 1'b1;
            end else if (l == int'(cnt_r)) begin
                word_s[l*WIDTH +: WIDTH] = in_data_i;
                keep_s[l]                = 1'b1;
            end else begin
                word_s[l*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                keep_s[l]                = 1'b0;
            end
        end
        if (cnt_r == CNT_MAX) begin
            word_s[(RATIO-1)*WIDTH +: WIDTH] = in_data_i;
            keep_s[RATIO-1]                  = 1'b1;
        end else begin
            word_s[(RATIO-1)*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            keep_s[RATIO-1]                  = 1'b0;
        end
    end

    // Lane counter and assembly buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
            buf_r <= '0;
        end else begin
            if (beat_acc_s && closing_s) begin
                cnt_r <= '0;
            end else if (beat_acc_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            for (int l = 0; l < RATIO - 1; l++) begin
                if (beat_acc_s && !closing_s && (l == int'(cnt_r))) begin
                    buf_r[l*WIDTH +: WIDTH] <= in_data_i;
                end
            end
        end
    end

    // Output register: a closing beat reloads it even while the old word drains (no bubble).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (beat_acc_s && closing_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= word_s;
            out_keep_r  <= keep_s;
            out_last_r  <= last_s;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_data_o  = out_data_r;
    assign out_valid_o = out_valid_r;
    assign out_keep_o  = out_keep_r;
    assign out_last_o  = out_last_r;

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer (WIDTH=8, RATIO=4): queue-based reference model
// compared every cycle, directed literal scenarios, then randomized traffic with resets.

module tb_stream_upsizer;

`ifdef STREAM_UPSIZER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_keep;
    logic        out_last;

    int n_checks = 0;
    int n_errors = 0;

    stream_upsizer #(.WIDTH(8), .RATIO(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_last_i   (in_last),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_keep_o  (out_keep),
        .out_last_o  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats of the word in progress plus the word held at the output.
    logic [7:0]  beats[$];
    bit          m_init = 1'b0;
    bit          m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    bit          m_last;
    bit          closing;
    bit          exp_ready;

    always @(negedge clk) begin
        closing   = (beats.size() == 3) || (LAST_EN && in_last);
        exp_ready = closing ? (!m_valid || out_ready) : 1'b1;
        if (m_init) begin
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_keep", out_keep, m_keep);
                chk("out_last", out_last, m_last);
            end
        end
        if (rst_i) begin
            beats.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_keep  = '0;
            m_last  = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            if (in_valid && exp_ready) begin
                beats.push_back(in_data);
            end
            if (in_valid && exp_ready && closing) begin
                m_data = '0;
                for (int k = 0; k < beats.size(); k++) begin
                    m_data = m_data | (32'(beats[k]) << (8 * k));
                end
                m_keep  = 4'((1 << beats.size()) - 1);
                m_last  = LAST_EN && in_last;
                m_valid = 1'b1;
                beats.delete();
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        wait_accept();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_keep"}, out_keep, 4'h0);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    int vpos[$];
    int ready_low;

    initial begin
        rst_i     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_reset_state("rst0");

        // Four back-to-back beats form 0x44332211 one cycle after the last one.
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h44;
        @(negedge clk);
        chk("t1_valid_before", out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_data, 32'h44332211);
        chk("t1_keep", out_keep, 4'hF);
        chk("t1_last", out_last, 1'b0);

        // Backpressure: three beats still accepted, the closing one stalls, then no bubble.
        out_ready = 1'b0;
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h88;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_ready", in_ready, 1'b0);
            chk("t2_hold_data", out_data, 32'h44332211);
            chk("t2_hold_valid", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        chk("t2_no_bubble", out_valid, 1'b1);
        chk("t2_data", out_data, 32'h88776655);
        @(posedge clk);
        #1;
        chk("t2_drained", out_valid, 1'b0);

        // Sixteen beats at full rate: four words, four cycles apart, input never stalled.
        ready_low = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            @(negedge clk);
            if (!in_ready) ready_low++;
            if (out_valid) vpos.push_back(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid) vpos.push_back(16);
        chk("t3_words", vpos.size(), 4);
        chk("t3_ready_low", ready_low, 0);
        if (vpos.size() > 0) chk("t3_first", vpos[0], 4);
        for (int k = 1; k < vpos.size(); k++) chk("t3_spacing", vpos[k] - vpos[k-1], 4);
        chk("t3_last_word", out_data, 32'h100F0E0D);
        @(posedge clk);
        #1;

        // Early close on in_last_i.
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
`ifdef STREAM_UPSIZER_LAST_EN
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_data", out_data, 32'h0000BBAA);
        chk("t4_keep", out_keep, 4'h3);
        chk("t4_last", out_last, 1'b1);
`else
        chk("t4_no_word", out_valid, 1'b0);
        beat(8'hCC, 1'b0);
        chk("t4_still_no_word", out_valid, 1'b0);
        beat(8'hDD, 1'b0);
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_data", out_data, 32'hDDCCBBAA);
        chk("t4_keep", out_keep, 4'hF);
        chk("t4_last", out_last, 1'b0);
`endif
        @(posedge clk);
        #1;

        // Reset mid-word discards the partial beats.
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_reset_state("rst1");
        beat(8'h0A, 1'b0);
        beat(8'h0B, 1'b0);
        beat(8'h0C, 1'b0);
        beat(8'h0D, 1'b0);
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data", out_data, 32'h0D0C0B0A);
        chk("t5_keep", out_keep, 4'hF);

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_i     = ($urandom_range(0, 249) == 0);
            @(posedge clk);
            #1;
        end
        rst_i     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
